// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: load-use interlock, branch redirect
// flushing, multi-cycle ALU stalls, debug halt draining and saturating event counters.
module hazard_ctrl #(
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 hz_clk,
  input  logic                 hz_rst,
  input  logic                 hz_i_ce,
  input  logic                 hz_i_halt,
  input  logic                 hz_i_ds_valid,
  input  logic [AWIDTH-1:0]    hz_i_ds_addr_rs1,
  input  logic [AWIDTH-1:0]    hz_i_ds_addr_rs2,
  input  logic                 hz_i_ds_use_rs1,
  input  logic                 hz_i_ds_use_rs2,
  input  logic                 hz_i_ex_valid,
  input  logic                 hz_i_ex_is_load,
  input  logic                 hz_i_ex_we_reg,
  input  logic [AWIDTH-1:0]    hz_i_ex_addr_rd,
  input  logic                 hz_i_ex_change_pc,
  input  logic [PC_WIDTH-1:0]  hz_i_ex_next_pc,
  input  logic                 hz_i_alu_busy,
  output logic                 hz_o_fi_stall,
  output logic                 hz_o_ds_stall,
  output logic                 hz_o_ex_stall,
  output logic                 hz_o_fi_flush,
  output logic                 hz_o_ds_flush,
  output logic                 hz_o_ex_bubble,
  output logic                 hz_o_redirect,
  output logic [PC_WIDTH-1:0]  hz_o_redirect_pc,
  output logic                 hz_o_halted,
  output logic [2:0]           hz_o_state,
  output logic [CNT_WIDTH-1:0] hz_o_stall_cnt,
  output logic [CNT_WIDTH-1:0] hz_o_flush_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0]    ADDR_ZERO  = {AWIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0]  PC_ZERO    = {PC_WIDTH{1'b0}};

  state_t               state_r;
  logic [2:0]           flush_left_r;
  logic                 lu_seen_r;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  logic                 redir_s;
  logic                 load_use_raw_s;
  logic                 load_use_s;
  logic                 active_s;
  logic                 drain_s;
  logic                 redir_take_s;
  logic                 lu_take_s;
  logic                 fi_stall_s;
  logic                 ds_stall_s;
  logic                 ex_stall_s;
  logic                 fi_flush_s;
  logic                 ds_flush_s;
  logic                 ex_bubble_s;
  logic                 redirect_s;
  logic [PC_WIDTH-1:0]  redirect_pc_s;
  logic                 halted_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // A load-use hazard is held for only one cycle: the bubble it inserts clears EX.
  assign redir_s        = hz_i_ex_valid & hz_i_ex_change_pc;
  assign load_use_raw_s = hz_i_ex_valid & hz_i_ex_is_load & hz_i_ex_we_reg &
                          (hz_i_ex_addr_rd != ADDR_ZERO) & hz_i_ds_valid &
                          ((hz_i_ds_use_rs1 & (hz_i_ds_addr_rs1 == hz_i_ex_addr_rd)) |
                           (hz_i_ds_use_rs2 & (hz_i_ds_addr_rs2 == hz_i_ex_addr_rd)));
  assign load_use_s     = load_use_raw_s & ~lu_seen_r;
  assign drain_s        = (state_r == ST_DRAIN);
  assign active_s       = (state_r == ST_RUN) | drain_s;
  assign redir_take_s   = active_s & ~hz_i_alu_busy & redir_s;
  assign lu_take_s      = active_s & ~hz_i_alu_busy & ~redir_s & load_use_s;

  // Per-state pipeline controls, forced to reset values while reset is held.
  always_comb begin
    fi_stall_s    = 1'b0;
    ds_stall_s    = 1'b0;
    ex_stall_s    = 1'b0;
    fi_flush_s    = 1'b0;
    ds_flush_s    = 1'b0;
    ex_bubble_s   = 1'b0;
    redirect_s    = 1'b0;
    redirect_pc_s = PC_ZERO;
    halted_s      = 1'b0;
    if (hz_rst) begin
      fi_stall_s = 1'b1;
      ds_stall_s = 1'b1;
      ex_stall_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          fi_stall_s = 1'b1;
          ds_stall_s = 1'b1;
          ex_stall_s = 1'b1;
        end
        ST_RUN, ST_DRAIN: begin
          fi_stall_s  = (active_s & hz_i_alu_busy) | lu_take_s | drain_s;
          ds_stall_s  = (active_s & hz_i_alu_busy) | lu_take_s;
          ex_stall_s  = active_s & hz_i_alu_busy;
          fi_flush_s  = redir_take_s;
          ds_flush_s  = redir_take_s;
          ex_bubble_s = lu_take_s;
          redirect_s  = redir_take_s;
        end
        ST_FLUSH: begin
          fi_flush_s = 1'b1;
          ds_flush_s = 1'b1;
        end
        ST_HALTED: begin
          fi_stall_s = 1'b1;
          ds_stall_s = 1'b1;
          ex_stall_s = 1'b1;
          halted_s   = 1'b1;
        end
        default: begin
          fi_stall_s = 1'b1;
          ds_stall_s = 1'b1;
          ex_stall_s = 1'b1;
        end
      endcase
      if (redirect_s) begin
        redirect_pc_s = hz_i_ex_next_pc;
      end else begin
        redirect_pc_s = PC_ZERO;
      end
    end
  end

  // Sequencing FSM, flush countdown, load-use guard and event counters.
  always_ff @(posedge hz_clk) begin
    if (hz_rst) begin
      state_r      <= ST_IDLE;
      flush_left_r <= 3'd0;
      lu_seen_r    <= 1'b0;
      stall_cnt_r  <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
    end else begin
      lu_seen_r <= lu_take_s;
      if ((active_s & hz_i_alu_busy) | lu_take_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (redir_take_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
      case (state_r)
        ST_IDLE: begin
          if (hz_i_ce) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hz_i_alu_busy) begin
            state_r <= ST_RUN;
          end else if (redir_s) begin
            if (FLUSH_CYCLES > 1) begin
              state_r      <= ST_FLUSH;
              flush_left_r <= FLUSH_LOAD;
            end
          end else if (load_use_s) begin
            state_r <= ST_RUN;
          end else if (hz_i_halt) begin
            state_r <= ST_DRAIN;
          end else if (!hz_i_ce) begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_left_r <= 3'd1) begin
            state_r      <= ST_RUN;
            flush_left_r <= 3'd0;
          end else begin
            flush_left_r <= flush_left_r - 3'd1;
          end
        end
        ST_DRAIN: begin
          if (!hz_i_ds_valid && !hz_i_ex_valid && !hz_i_alu_busy) begin
            state_r <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (!hz_i_halt) begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign hz_o_fi_stall    = fi_stall_s;
  assign hz_o_ds_stall    = ds_stall_s;
  assign hz_o_ex_stall    = ex_stall_s;
  assign hz_o_fi_flush    = fi_flush_s;
  assign hz_o_ds_flush    = ds_flush_s;
  assign hz_o_ex_bubble   = ex_bubble_s;
  assign hz_o_redirect    = redirect_s;
  assign hz_o_redirect_pc = redirect_pc_s;
  assign hz_o_halted      = halted_s;
  assign hz_o_state       = hz_rst ? 3'd0 : state_r;
  assign hz_o_stall_cnt   = hz_rst ? CNT_ZERO : stall_cnt_r;
  assign hz_o_flush_cnt   = hz_rst ? CNT_ZERO : flush_cnt_r;

endmodule
